// File: rtl/ex_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_pkg
// Description : Shared definitions for the iterative multiply/divide unit.
//               This file holds the op encodings, the FSM state encoding and
//               the default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_muldiv_pkg;

    localparam int MD_WIDTH_DEFAULT = 32;

    // Operation encodings presented on op_i
    localparam logic [1:0] MD_MUL  = 2'b00;
    localparam logic [1:0] MD_MULU = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;
    localparam logic [1:0] MD_DIVU = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL_RUN  = 3'd1,
        ST_DIV_RUN  = 3'd2,
        ST_DIV_ZERO = 3'd3,
        ST_DONE     = 3'd4
    } md_state_e;

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_div_step.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_div_step
// Description : One combinational restoring-division step. The next dividend
//               bit is shifted into the partial remainder, and a trial
//               subtraction of the divisor is made. The subtraction is kept
//               only when it does not borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_div_step
    import ex_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_dividend_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    assign w_shifted = {i_rem, i_dividend_bit};
    assign w_trial   = w_shifted - {1'b0, i_divisor};

    // The shifted remainder is always below 2*divisor. A set top bit therefore
    // means the subtraction fits. Otherwise, bit WIDTH of the trial result is
    // the borrow.
    assign o_q_bit = w_shifted[WIDTH] | ~w_trial[WIDTH];
    assign o_rem   = o_q_bit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv
// Description : Iterative signed/unsigned multiply and divide unit for the
//               execute stage. The multiply is shift-add and the divide is
//               restoring. Each produces one bit per cycle. Signed operands
//               are processed as magnitudes, and the sign is fixed up when
//               the result is written.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               div_by_zero_o
);

    localparam int               CNT_W       = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(WIDTH - 1);

    md_state_e          r_state;
    md_state_e          w_state_nxt;

    logic [WIDTH-1:0]   r_a;          // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] r_acc;        // MUL: {partial, multiplier}; DIV: {rem, dividend/quotient}
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_q;      // negate product / quotient at the end
    logic               r_neg_r;      // negate remainder at the end
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;
    logic               r_dbz;

    logic               w_accept;
    logic               w_signed;
    logic               w_is_div;
    logic               w_op2_zero;
    logic               w_sign1;
    logic               w_sign2;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic               w_last;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [2*WIDTH-1:0] w_mul_fix;
    logic [WIDTH-1:0]   w_div_rem;
    logic               w_div_q;
    logic [2*WIDTH-1:0] w_div_nxt;
    logic [2*WIDTH-1:0] w_div_fix;

    assign w_accept   = (r_state == ST_IDLE) && start_i && !annul_i;
    assign w_signed   = (op_i == MD_MUL) || (op_i == MD_DIV);
    assign w_is_div   = (op_i == MD_DIV) || (op_i == MD_DIVU);
    assign w_op2_zero = (opdata2_i == '0);
    assign w_sign1    = w_signed & opdata1_i[WIDTH-1];
    assign w_sign2    = w_signed & opdata2_i[WIDTH-1];
    assign w_mag1     = w_sign1 ? -opdata1_i : opdata1_i;
    assign w_mag2     = w_sign2 ? -opdata2_i : opdata2_i;
    assign w_last     = (r_cnt == C_LAST_ITER);

    // Shift-add step: conditionally add the multiplicand to the upper half,
    // then shift the whole accumulator right by one bit.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_mul_fix = r_neg_q ? -w_mul_nxt : w_mul_nxt;

    ex_muldiv_div_step #(
        .WIDTH          (WIDTH)
    ) u_div_step (
        .i_rem          (r_acc[2*WIDTH-1:WIDTH]),
        .i_dividend_bit (r_acc[WIDTH-1]),
        .i_divisor      (r_a),
        .o_rem          (w_div_rem),
        .o_q_bit        (w_div_q)
    );

    // The dividend shifts out of the low half as quotient bits shift in.
    assign w_div_nxt = {w_div_rem, r_acc[WIDTH-2:0], w_div_q};
    assign w_div_fix = {(r_neg_r ? -w_div_nxt[2*WIDTH-1:WIDTH] : w_div_nxt[2*WIDTH-1:WIDTH]),
                        (r_neg_q ? -w_div_nxt[WIDTH-1:0]       : w_div_nxt[WIDTH-1:0])};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; annul takes priority over everything else
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_is_div)       w_state_nxt = ST_MUL_RUN;
                    else if (w_op2_zero) w_state_nxt = ST_DIV_ZERO;
                    else                 w_state_nxt = ST_DIV_RUN;
                end
            end
            ST_MUL_RUN, ST_DIV_RUN: begin
                if (annul_i)     w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DIV_ZERO: begin
                w_state_nxt = annul_i ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (annul_i || !start_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, per-cycle iteration and result write-back
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            // Ready follows one cycle behind DONE and drops as soon as DONE is left
            r_ready <= (r_state == ST_DONE) && (w_state_nxt == ST_DONE);
            if (w_accept) begin
                r_cnt   <= '0;
                r_neg_q <= w_sign1 ^ w_sign2;
                r_neg_r <= w_sign1;
                r_dbz   <= w_is_div & w_op2_zero;
                if (w_is_div) begin
                    r_a   <= w_mag2;
                    r_acc <= {{WIDTH{1'b0}}, w_mag1};
                end else begin
                    r_a   <= w_mag1;
                    r_acc <= {{WIDTH{1'b0}}, w_mag2};
                end
                if (w_is_div && w_op2_zero) begin
                    r_result <= '0;
                end
            end else if ((r_state == ST_MUL_RUN) && !annul_i) begin
                r_acc <= w_mul_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_result <= w_mul_fix;
                end
            end else if ((r_state == ST_DIV_RUN) && !annul_i) begin
                r_acc <= w_div_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_result <= w_div_fix;
                end
            end
        end
    end

    assign result_o      = r_result;
    assign ready_o       = r_ready;
    assign div_by_zero_o = r_dbz;
    assign busy_o        = (r_state == ST_MUL_RUN) || (r_state == ST_DIV_RUN) ||
                           (r_state == ST_DIV_ZERO);

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv
// Description : Scoreboard bench for ex_muldiv. The bench uses directed
//               vectors plus randomized operations, which are checked against
//               an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [2*W-1:0] res;
        logic           dbz;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start_i = 1'b0;
    logic [1:0]     op_i = 2'b00;
    logic [W-1:0]   opdata1_i = '0;
    logic [W-1:0]   opdata2_i = '0;
    logic           annul_i = 1'b0;
    logic [2*W-1:0] result_o;
    logic           ready_o;
    logic           busy_o;
    logic           div_by_zero_o;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    ex_muldiv #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .op_i          (op_i),
        .opdata1_i     (opdata1_i),
        .opdata2_i     (opdata2_i),
        .annul_i       (annul_i),
        .result_o      (result_o),
        .ready_o       (ready_o),
        .busy_o        (busy_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.dbz = 1'b0;
        e.res = '0;
        case (op)
            MD_MUL:  e.res = sa * sb;
            MD_MULU: e.res = {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                if (b == 0) e.dbz = 1'b1;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    e.res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) e.dbz = 1'b1;
                else e.res = {a % b, a / b};
            end
        endcase
        return e;
    endfunction

    // Full handshake: start, count latency and busy cycles, hold, release
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input exp_t e);
        int lat = -1;
        int busy_cnt = 0;
        int exp_lat;
        int exp_busy;
        bit seen = 0;
        exp_lat  = (op[1] && b == 0) ? 2 : W + 1;
        exp_busy = (op[1] && b == 0) ? 1 : W;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b;
        @(posedge clk);                       // edge 0: start accepted
        for (int k = 0; k < W + 10 && !seen; k++) begin
            @(negedge clk);                   // after edge k
            if (busy_o) busy_cnt++;
            if (ready_o) begin
                seen = 1;
                lat = k;
            end else begin
                @(posedge clk);
            end
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
        @(posedge clk);
        @(negedge clk);
        check("ready_hold", 64'(ready_o), 64'd1);
        check("busy_in_done", 64'(busy_o), 64'd0);
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_drop", 64'(ready_o), 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compare each newly presented result against the scoreboard
    initial begin
        logic prev_ready;
        exp_t e;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (ready_o && !prev_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready: got=1 want=0 (no operation pending)");
                end else begin
                    e = exp_q.pop_front();
                    check("result", result_o, e.res);
                    check("div_by_zero", 64'(div_by_zero_o), 64'(e.dbz));
                end
            end
            prev_ready = ready_o;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [1:0] op;
        logic [W-1:0] a, b;

        #2;
        check("rst_result", result_o, 64'd0);
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_dbz", 64'(div_by_zero_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed vectors with independently known answers
        run_op(MD_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{64'hFFFF_FFFE_0000_0001, 1'b0});
        run_op(MD_MUL,  32'hFFFF_FFFD, 32'd7,         '{64'hFFFF_FFFF_FFFF_FFEB, 1'b0});
        run_op(MD_DIV,  32'hFFFF_FFF9, 32'd2,         '{64'hFFFF_FFFF_FFFF_FFFD, 1'b0});
        run_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, '{64'h0000_0000_8000_0000, 1'b0});
        run_op(MD_DIVU, 32'd100,       32'd0,         '{64'd0, 1'b1});
        run_op(MD_MULU, 32'd2,         32'd3,         '{64'd6, 1'b0});

        // Annul partway through a divide
        @(posedge clk); #1;
        start_i = 1'b1; op_i = MD_DIV; opdata1_i = 32'd1000; opdata2_i = 32'd7;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1 annul_i = 1'b1;
        @(posedge clk);
        #1 annul_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        check("annul_busy", 64'(busy_o), 64'd0);
        seen = 0;
        repeat (W + 5) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        check("annul_no_ready", 64'(seen), 64'd0);

        run_op(MD_DIVU, 32'd1000, 32'd7, '{{32'd6, 32'd142}, 1'b0});

        // Asynchronous reset in the middle of a divide
        @(posedge clk); #1;
        start_i = 1'b1; op_i = MD_DIVU; opdata1_i = 32'd12345; opdata2_i = 32'd13;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_rst_result", result_o, 64'd0);
        check("async_rst_ready", 64'(ready_o), 64'd0);
        check("async_rst_busy", 64'(busy_o), 64'd0);
        check("async_rst_dbz", 64'(div_by_zero_o), 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        run_op(MD_MULU, 32'd9, 32'd11, '{64'd99, 1'b0});

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            run_op(op, a, b, model(op, a, b));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Parametrised iterative multiply/divide unit for the execute stage.
- Executes signed/unsigned multiply and divide over WIDTH-bit operands and returns a 2*WIDTH {hi,lo} result for the HI/LO path.
- The execute stage holds start_i and raises its stall request while ready_o is low.
- Successor to the single-cycle ALU: adds multi-cycle operation, a start/ready handshake, annulment and divide-by-zero reporting.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 4
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
start_i  input  1  request; held high by the execute stage until it consumes the result
op_i  input  2  00 MUL signed, 01 MULU, 10 DIV signed, 11 DIVU
opdata1_i  input  WIDTH  multiplicand / dividend
opdata2_i  input  WIDTH  multiplier / divisor
annul_i  input  1  flush; abandons the operation in flight
result_o  output  2*WIDTH  MUL: {hi,lo} product; DIV: {remainder, quotient}
ready_o  output  1  result_o valid
busy_o  output  1  iteration in progress (MUL_RUN / DIV_RUN / DIV_ZERO)
div_by_zero_o  output  1  last completed operation was a divide by zero

Behaviour:
- Reset: rst low forces IDLE immediately, regardless of clk. result_o=0, ready_o=0, busy_o=0, div_by_zero_o=0, counter=0.
- States: IDLE, MUL_RUN, DIV_RUN, DIV_ZERO, DONE.
- IDLE:
  - start_i=1 and annul_i=0 latches operands and op and clears the counter.
  - Next state: MUL_RUN for op 0x/1x with op[1]=0; for divides, DIV_ZERO if opdata2_i==0, else DIV_RUN.
  - start_i with annul_i=1 is ignored.
- Signed ops (00, 10):
  - Operands are latched as magnitudes.
  - Product sign = sign1 XOR sign2.
  - Quotient sign = sign1 XOR sign2; remainder sign = dividend sign.
  - Sign correction (two's complement negate) is applied on the transition into DONE.
- MUL_RUN: shift-add, one multiplier bit per cycle, WIDTH cycles, 2*WIDTH accumulator.
- DIV_RUN: restoring division, one quotient bit per cycle, WIDTH cycles.
  - Each step uses a WIDTH+1-bit trial subtraction.
  - Most-negative / -1 yields quotient 0x80..0 (wrap) and remainder 0; no exception is raised.
- DIV_ZERO: one cycle; result_o=0, div_by_zero_o=1, then DONE.
- Latency, with the start accepted at edge 0:
  - ready_o rises after edge WIDTH+1 for MUL/DIV.
  - ready_o rises after edge 2 for divide by zero.
- DONE:
  - ready_o=1, busy_o=0; result_o and div_by_zero_o are stable.
  - Stays in DONE while start_i=1.
  - start_i=0 moves to IDLE; ready_o drops on the next edge. result_o holds its value until the next accepted start.
- annul_i=1 in MUL_RUN, DIV_RUN, DIV_ZERO or DONE: next state IDLE, ready_o=0, result_o unchanged. An annulled operation never raises ready_o.
- If annul_i and start_i are both high in any state, annul wins.
- div_by_zero_o clears on the next accepted start.
- busy_o=1 exactly in MUL_RUN, DIV_RUN and DIV_ZERO.

Decomposition:
- Shared package holds:
  - op encodings MD_MUL, MD_MULU, MD_DIV, MD_DIVU
  - state encoding (3-bit) for ex_muldiv
  - default WIDTH
- One natural sub-module: div_step, a combinational single restoring-division step (partial remainder, divisor, next remainder, quotient bit). It is instantiated once and reused each cycle.

Test Plan:
- MULU 0xFFFFFFFF x 0xFFFFFFFF -> result_o=0xFFFFFFFE_00000001, ready_o high after edge 33.
- MUL signed 0xFFFFFFFD (-3) x 7 -> result_o=0xFFFFFFFF_FFFFFFEB; start_i then dropped -> ready_o low after the next edge.
- DIV signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- DIVU 100 / 0 -> ready_o after edge 2, result_o=0, div_by_zero_o=1, busy_o=1 for one cycle. A following MULU 2x3 -> div_by_zero_o=0 and result 6.
- DIV 1000/7 with annul_i pulsed at iteration 10 -> busy_o=0 next cycle, ready_o never rises. A new DIVU 1000/7 -> quotient 142, remainder 6.
- rst driven low mid-DIV_RUN, between clock edges -> all outputs 0 immediately. After rst goes high, the unit is IDLE and accepts a new start.
